// File: rtl/fabric_reset_sequencer.sv
// Lock-qualified reset sequencer: waits for a stable PLL lock, then releases reset domains in order.
// Optional lock-loss counter is built when FAB_RST_LOCK_LOST_CNT_EN is defined.
module fabric_reset_sequencer #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int STAGE_GAP          = 16,
  parameter int NUM_STAGES         = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  LOCK,
  input  logic                  SW_RST_REQ,
  output logic [NUM_STAGES-1:0] FAB_RST_N,
  output logic                  READY,
  output logic [1:0]            STATE,
  output logic [7:0]            LOCK_LOST_CNT
);

  localparam int CW = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
  localparam int GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
  localparam int IW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST    = GW'(STAGE_GAP - 1);
  localparam logic [IW-1:0] IDX_LAST    = IW'(NUM_STAGES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_e;

  state_e                  state_q;
  logic [1:0]              lock_sync_q;
  logic                    lock_s;
  logic [CW-1:0]           stable_cnt_q;
  logic [GW-1:0]           gap_q;
  logic [IW-1:0]           idx_q;
  logic [NUM_STAGES-1:0]   fab_q;
  logic                    ready_q;

  assign lock_s = lock_sync_q[1];

  // Two-flop synchronizer: the only place LOCK is sampled.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lock_sync_q <= 2'b00;
    end else begin
      lock_sync_q <= {lock_sync_q[0], LOCK};
    end
  end

  // Sequencer FSM; priority is lock loss, then soft reset, then normal stepping.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= WAIT_LOCK;
      stable_cnt_q <= '0;
      gap_q        <= '0;
      idx_q        <= '0;
      fab_q        <= '0;
      ready_q      <= 1'b0;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          fab_q   <= '0;
          ready_q <= 1'b0;
          if (lock_s) begin
            state_q      <= STABLE;
            stable_cnt_q <= '0;
          end else begin
            state_q <= WAIT_LOCK;
          end
        end
        STABLE: begin
          if (!lock_s) begin
            state_q <= WAIT_LOCK;
          end else if (stable_cnt_q == STABLE_LAST) begin
            state_q <= RELEASE;
            idx_q   <= '0;
            gap_q   <= '0;
          end else begin
            stable_cnt_q <= stable_cnt_q + CW'(1);
          end
        end
        RELEASE: begin
          if (!lock_s) begin
            state_q <= WAIT_LOCK;
            fab_q   <= '0;
            ready_q <= 1'b0;
          end else if (SW_RST_REQ) begin
            idx_q   <= '0;
            gap_q   <= '0;
            fab_q   <= '0;
            ready_q <= 1'b0;
          end else if (gap_q == GAP_LAST) begin
            fab_q[idx_q] <= 1'b1;
            gap_q        <= '0;
            if (idx_q == IDX_LAST) begin
              state_q <= RUN;
              ready_q <= 1'b1;
            end else begin
              idx_q <= idx_q + IW'(1);
            end
          end else begin
            gap_q <= gap_q + GW'(1);
          end
        end
        RUN: begin
          if (!lock_s) begin
            state_q <= WAIT_LOCK;
            fab_q   <= '0;
            ready_q <= 1'b0;
          end else if (SW_RST_REQ) begin
            state_q <= RELEASE;
            idx_q   <= '0;
            gap_q   <= '0;
            fab_q   <= '0;
            ready_q <= 1'b0;
          end else begin
            fab_q   <= '1;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= WAIT_LOCK;
          fab_q   <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign FAB_RST_N = fab_q;
  assign READY     = ready_q;
  assign STATE     = state_q;

`ifdef FAB_RST_LOCK_LOST_CNT_EN
  logic [7:0] lost_cnt_q;
  logic [7:0] lost_cnt_d;
  logic       lost_evt_s;

  // Only losses after release has started are counted.
  assign lost_evt_s = !lock_s && ((state_q == RELEASE) || (state_q == RUN));

  // Saturating next value for the lock-loss counter.
  always_comb begin
    lost_cnt_d = lost_cnt_q;
    if (lost_evt_s && (lost_cnt_q != 8'hFF)) begin
      lost_cnt_d = lost_cnt_q + 8'd1;
    end else begin
      lost_cnt_d = lost_cnt_q;
    end
  end

  // Lock-loss counter register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lost_cnt_q <= 8'd0;
    end else begin
      lost_cnt_q <= lost_cnt_d;
    end
  end

  assign LOCK_LOST_CNT = lost_cnt_q;
`else
  assign LOCK_LOST_CNT = 8'd0;
`endif

endmodule

// File: tb/tb_fabric_reset_sequencer.sv
// Directed bench for fabric_reset_sequencer (L=8, G=4, N=3); expectations are queued with
// their target edge and checked by a negedge monitor.
module tb_fabric_reset_sequencer;

  logic       CLK;
  logic       RST;
  logic       LOCK;
  logic       SW_RST_REQ;
  logic [2:0] FAB_RST_N;
  logic       READY;
  logic [1:0] STATE;
  logic [7:0] LOCK_LOST_CNT;

`ifdef FAB_RST_LOCK_LOST_CNT_EN
  localparam logic [7:0] CNT_MASK = 8'hFF;
`else
  localparam logic [7:0] CNT_MASK = 8'h00;
`endif

  typedef struct {
    int         at;
    string      tag;
    logic [2:0] fab;
    logic       rdy;
    logic [1:0] st;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   b;

  fabric_reset_sequencer #(
    .LOCK_STABLE_CYCLES(8),
    .STAGE_GAP         (4),
    .NUM_STAGES        (3)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .LOCK         (LOCK),
    .SW_RST_REQ   (SW_RST_REQ),
    .FAB_RST_N    (FAB_RST_N),
    .READY        (READY),
    .STATE        (STATE),
    .LOCK_LOST_CNT(LOCK_LOST_CNT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [7:0] sat(int n);
    return ((n > 255) ? 8'd255 : 8'(n)) & CNT_MASK;
  endfunction

  task automatic chk(string tag, logic [2:0] ef, logic er, logic [1:0] es, logic [7:0] ec);
    n_vec++;
    assert ({FAB_RST_N, READY, STATE, LOCK_LOST_CNT} === {ef, er, es, ec}) else begin
      n_err++;
      $error("FAIL %s @edge %0d: got fab=%b ready=%b state=%0d cnt=%0d, expected fab=%b ready=%b state=%0d cnt=%0d",
             tag, cyc, FAB_RST_N, READY, STATE, LOCK_LOST_CNT, ef, er, es, ec);
    end
  endtask

  task automatic push(int at, string tag, logic [2:0] f, logic r, logic [1:0] s, logic [7:0] c);
    exp_t e;
    e.at = at; e.tag = tag; e.fab = f; e.rdy = r; e.st = s; e.cnt = c;
    sb.push_back(e);
  endtask

  task automatic wait_cyc(int n);
    while (cyc < n) @(negedge CLK);
  endtask

  // Scoreboard monitor: compare every expectation due at the edge just taken.
  always @(negedge CLK) begin
    while (sb.size() != 0 && sb[0].at <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.at < cyc) begin
        n_vec++;
        n_err++;
        $error("FAIL %s: check for edge %0d reached late at edge %0d", e.tag, e.at, cyc);
      end else begin
        chk(e.tag, e.fab, e.rdy, e.st, e.cnt);
      end
    end
  end

  initial begin
    RST = 1'b1; LOCK = 1'b0; SW_RST_REQ = 1'b0;
    repeat (2) @(negedge CLK);
    chk("reset", 3'b000, 1'b0, 2'd0, 8'd0);
    RST = 1'b0;
    @(negedge CLK);

    // Instability: LOCK low for edges 8..10, high again from edge 11.
    b = cyc; LOCK = 1'b1;
    push(b + 9,  "instab_pre",     3'b000, 1'b0, 2'd1, 8'd0);
    push(b + 10, "instab_wait",    3'b000, 1'b0, 2'd0, 8'd0);
    push(b + 12, "instab_hold",    3'b000, 1'b0, 2'd0, 8'd0);
    push(b + 13, "instab_restart", 3'b000, 1'b0, 2'd1, 8'd0);
    push(b + 20, "instab_count",   3'b000, 1'b0, 2'd1, 8'd0);
    push(b + 21, "instab_release", 3'b000, 1'b0, 2'd2, 8'd0);
    push(b + 24, "instab_gap",     3'b000, 1'b0, 2'd2, 8'd0);
    push(b + 25, "instab_s0",      3'b001, 1'b0, 2'd2, 8'd0);
    push(b + 29, "instab_s1",      3'b011, 1'b0, 2'd2, 8'd0);
    push(b + 32, "instab_pre_s2",  3'b011, 1'b0, 2'd2, 8'd0);
    push(b + 33, "instab_run",     3'b111, 1'b1, 2'd3, 8'd0);
    wait_cyc(b + 7);  LOCK = 1'b0;
    wait_cyc(b + 10); LOCK = 1'b1;
    wait_cyc(b + 35);

    // Lock loss in RUN, then full resequence with power-up offsets.
    b = cyc; LOCK = 1'b0;
    push(b + 2, "loss_lag",  3'b111, 1'b1, 2'd3, 8'd0);
    push(b + 3, "loss_drop", 3'b000, 1'b0, 2'd0, sat(1));
    wait_cyc(b + 5);
    b = cyc; LOCK = 1'b1;
    push(b + 2,  "pu_wait",    3'b000, 1'b0, 2'd0, sat(1));
    push(b + 3,  "pu_stable",  3'b000, 1'b0, 2'd1, sat(1));
    push(b + 10, "pu_count",   3'b000, 1'b0, 2'd1, sat(1));
    push(b + 11, "pu_release", 3'b000, 1'b0, 2'd2, sat(1));
    push(b + 14, "pu_gap",     3'b000, 1'b0, 2'd2, sat(1));
    push(b + 15, "pu_s0",      3'b001, 1'b0, 2'd2, sat(1));
    push(b + 19, "pu_s1",      3'b011, 1'b0, 2'd2, sat(1));
    push(b + 22, "pu_pre_s2",  3'b011, 1'b0, 2'd2, sat(1));
    push(b + 23, "pu_run",     3'b111, 1'b1, 2'd3, sat(1));
    wait_cyc(b + 25);

    // Soft reset held for 5 edges in RUN.
    b = cyc; SW_RST_REQ = 1'b1;
    push(b + 1, "sw_first", 3'b000, 1'b0, 2'd2, sat(1));
    push(b + 3, "sw_hold",  3'b000, 1'b0, 2'd2, sat(1));
    push(b + 5, "sw_last",  3'b000, 1'b0, 2'd2, sat(1));
    wait_cyc(b + 5); SW_RST_REQ = 1'b0;
    push(b + 8,  "sw_gap", 3'b000, 1'b0, 2'd2, sat(1));
    push(b + 9,  "sw_s0",  3'b001, 1'b0, 2'd2, sat(1));
    push(b + 13, "sw_s1",  3'b011, 1'b0, 2'd2, sat(1));
    push(b + 17, "sw_run", 3'b111, 1'b1, 2'd3, sat(1));
    wait_cyc(b + 18);

    // Asynchronous RST while FAB_RST_N=001.
    b = cyc; SW_RST_REQ = 1'b1;
    wait_cyc(b + 1); SW_RST_REQ = 1'b0;
    push(b + 5, "pre_rst", 3'b001, 1'b0, 2'd2, sat(1));
    wait_cyc(b + 5);
    #2 RST = 1'b1;
    #1 chk("async_rst", 3'b000, 1'b0, 2'd0, 8'd0);
    push(b + 6, "rst_held", 3'b000, 1'b0, 2'd0, 8'd0);
    wait_cyc(b + 7); RST = 1'b0;
    b = cyc;
    push(b + 2,  "rst_wait",    3'b000, 1'b0, 2'd0, 8'd0);
    push(b + 3,  "rst_stable",  3'b000, 1'b0, 2'd1, 8'd0);
    push(b + 11, "rst_release", 3'b000, 1'b0, 2'd2, 8'd0);
    push(b + 15, "rst_s0",      3'b001, 1'b0, 2'd2, 8'd0);
    push(b + 23, "rst_run",     3'b111, 1'b1, 2'd3, 8'd0);
    wait_cyc(b + 24);

    // Saturation: 300 lock-loss events, each taken in RUN or RELEASE.
    for (int i = 0; i < 300; i++) begin
      b = cyc; LOCK = 1'b1;
      wait_cyc(b + 12); LOCK = 1'b0;
      push(b + 15, "sat_drop", 3'b000, 1'b0, 2'd0, sat(i + 1));
      wait_cyc(b + 16);
    end

    repeat (2) @(negedge CLK);
    while (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      n_vec++;
      n_err++;
      $error("FAIL %s: check for edge %0d never reached (edge now %0d)", e.tag, e.at, cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
